// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO (read and write controllers).
// Holds the default geometry plus the pointer/occupancy and entry types at that geometry.
package fifo_pkg;

    // Default address width: depth is 2**FIFO_BIT_SIZE entries.
    localparam int unsigned FIFO_BIT_SIZE   = 10;
    // Default width of one FIFO entry.
    localparam int unsigned FIFO_DATA_WIDTH = 8;

    // Pointers and occupancy carry one extra bit; the MSB is the wrap bit.
    typedef logic [FIFO_BIT_SIZE:0]     ptr_t;
    typedef logic [FIFO_DATA_WIDTH-1:0] entry_t;

endpackage

// File: rtl/fifo_read_if.sv
// Read-side bundle of the asynchronous FIFO.
// slave  : the read controller (consumes read_enable/wptr/mem_rdata, drives the rest).
// master : the consumer/RAM/sync environment around the read controller.
interface fifo_read_if import fifo_pkg::*; #(
    parameter int unsigned BIT_SIZE   = FIFO_BIT_SIZE,
    parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH
) ();

    logic                  read_enable;   // pop request
    logic [BIT_SIZE:0]     wptr;          // write pointer, synchronized into rclk
    logic [DATA_WIDTH-1:0] mem_rdata;     // RAM data, one cycle after ren
    logic [BIT_SIZE-1:0]   raddr;         // RAM read address
    logic                  ren;           // RAM read enable (accepted pop)
    logic [BIT_SIZE:0]     rptr;          // read pointer for the write side
    logic                  empty;         // registered empty flag
    logic [BIT_SIZE:0]     fifo_occu_out; // registered read-domain occupancy
    logic [DATA_WIDTH-1:0] dout;          // output data, stable between pops
    logic                  dout_valid;    // pulse: new data on dout
    logic                  underflow;     // pulse: pop requested while empty

    modport slave (
        input  read_enable, wptr, mem_rdata,
        output raddr, ren, rptr, empty, fifo_occu_out, dout, dout_valid, underflow
    );

    modport master (
        output read_enable, wptr, mem_rdata,
        input  raddr, ren, rptr, empty, fifo_occu_out, dout, dout_valid, underflow
    );

endinterface

// File: rtl/fifo_read.sv
// Read-side controller of the asynchronous FIFO, entirely in the rclk domain.
// Owns the read pointer, drives the RAM read port, and produces the empty flag,
// occupancy, underflow pulse and a valid-qualified, held data output.
// Ports:
//   rclk  - read clock
//   reset - synchronous active-high reset
//   bus   - fifo_read_if.slave (read_enable, wptr, mem_rdata in; raddr, ren, rptr,
//           empty, fifo_occu_out, dout, dout_valid, underflow out)
module fifo_read import fifo_pkg::*; #(
    parameter int unsigned BIT_SIZE   = FIFO_BIT_SIZE,
    parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH
) (
    input logic       rclk,
    input logic       reset,
    fifo_read_if.slave bus
);

    logic [BIT_SIZE:0]     rptr_q, rptr_d;
    logic [BIT_SIZE:0]     occu_q, occu_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  empty_q, empty_d;
    logic                  dout_valid_q, dout_valid_d;
    logic                  underflow_q, underflow_d;

    logic empty_fifo;
    logic pop;

    // Compare full width so a wrapped-but-equal address is not mistaken for empty.
    assign empty_fifo = (rptr_q == bus.wptr);
    // Reset gates the RAM read so nothing is launched during reset.
    assign pop = bus.read_enable && !empty_fifo && !reset;

    always_comb begin
        rptr_d       = rptr_q;
        hold_d       = hold_q;
        occu_d       = bus.wptr - rptr_q;
        empty_d      = empty_fifo;
        dout_valid_d = pop;
        underflow_d  = bus.read_enable && empty_fifo;
        if (pop) begin
            // Natural modulo wrap toggles the MSB.
            rptr_d = rptr_q + {{BIT_SIZE{1'b0}}, 1'b1};
        end
        if (dout_valid_q) begin
            hold_d = bus.mem_rdata;
        end
    end

    always_ff @(posedge rclk) begin
        if (reset) begin
            rptr_q       <= '0;
            occu_q       <= '0;
            hold_q       <= '0;
            empty_q      <= 1'b1;
            dout_valid_q <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            rptr_q       <= rptr_d;
            occu_q       <= occu_d;
            hold_q       <= hold_d;
            empty_q      <= empty_d;
            dout_valid_q <= dout_valid_d;
            underflow_q  <= underflow_d;
        end
    end

    assign bus.ren           = pop;
    assign bus.raddr         = rptr_q[BIT_SIZE-1:0];
    assign bus.rptr          = rptr_q;
    assign bus.empty         = empty_q;
    assign bus.fifo_occu_out = occu_q;
    assign bus.dout_valid    = dout_valid_q;
    assign bus.underflow     = underflow_q;
    // RAM data passes straight through in its valid cycle, otherwise the last captured word.
    assign bus.dout          = dout_valid_q ? bus.mem_rdata : hold_q;

endmodule

// File: tb/tb_fifo_read.sv
// Directed bench for fifo_read at BIT_SIZE=4, DATA_WIDTH=8 with a behavioural RAM.
module tb_fifo_read;

    localparam int unsigned BS = 4;
    localparam int unsigned DW = 8;

    logic rclk;
    logic reset;

    fifo_read_if #(.BIT_SIZE(BS), .DATA_WIDTH(DW)) bus ();

    fifo_read #(.BIT_SIZE(BS), .DATA_WIDTH(DW)) dut (
        .rclk  (rclk),
        .reset (reset),
        .bus   (bus)
    );

    logic [DW-1:0] mem [16];

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    // Synchronous-read RAM: data appears the cycle after ren.
    always @(posedge rclk) begin
        if (reset) bus.mem_rdata <= '0;
        else if (bus.ren) bus.mem_rdata <= mem[bus.raddr];
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge rclk);
        #1;
    endtask

    typedef struct {
        logic          re;
        logic [BS:0]   wptr;
        logic          ren;
        logic [BS-1:0] raddr;
        logic [BS:0]   rptr;
        logic          dv;
        logic [DW-1:0] dout;
        logic          empty;
        logic [BS:0]   occu;
        logic          uf;
    } vec_t;

    vec_t vecs [9];

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'hA1 + 8'(i);

        // re, wptr | ren, raddr | after edge: rptr, dv, dout, empty, occu, uf
        vecs[0] = '{1'b1, 5'd3, 1'b1, 4'd0, 5'd1, 1'b1, 8'hA1, 1'b0, 5'd3, 1'b0};
        vecs[1] = '{1'b1, 5'd3, 1'b1, 4'd1, 5'd2, 1'b1, 8'hA2, 1'b0, 5'd2, 1'b0};
        vecs[2] = '{1'b1, 5'd3, 1'b1, 4'd2, 5'd3, 1'b1, 8'hA3, 1'b0, 5'd1, 1'b0};
        vecs[3] = '{1'b1, 5'd3, 1'b0, 4'd3, 5'd3, 1'b0, 8'hA3, 1'b1, 5'd0, 1'b1};
        vecs[4] = '{1'b0, 5'd3, 1'b0, 4'd3, 5'd3, 1'b0, 8'hA3, 1'b1, 5'd0, 1'b0};
        vecs[5] = '{1'b1, 5'd5, 1'b1, 4'd3, 5'd4, 1'b1, 8'hA4, 1'b0, 5'd2, 1'b0};
        vecs[6] = '{1'b1, 5'd5, 1'b1, 4'd4, 5'd5, 1'b1, 8'hA5, 1'b0, 5'd1, 1'b0};
        vecs[7] = '{1'b1, 5'd5, 1'b0, 4'd5, 5'd5, 1'b0, 8'hA5, 1'b1, 5'd0, 1'b1};
        vecs[8] = '{1'b0, 5'd5, 1'b0, 4'd5, 5'd5, 1'b0, 8'hA5, 1'b1, 5'd0, 1'b0};

        reset = 1'b1;
        bus.read_enable = 1'b0;
        bus.wptr = '0;
        step();
        step();
        check("rst_rptr", 32'(bus.rptr), 32'd0);
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_occu", 32'(bus.fifo_occu_out), 32'd0);
        check("rst_dv", 32'(bus.dout_valid), 32'd0);
        check("rst_uf", 32'(bus.underflow), 32'd0);
        check("rst_dout", 32'(bus.dout), 32'd0);
        check("rst_ren", 32'(bus.ren), 32'd0);
        reset = 1'b0;

        // Three pops then underflow; then pop to rptr=wptr=5 and underflow again.
        for (int v = 0; v < 9; v++) begin
            bus.read_enable = vecs[v].re;
            bus.wptr = vecs[v].wptr;
            #1;
            check($sformatf("v%0d_ren", v), 32'(bus.ren), 32'(vecs[v].ren));
            check($sformatf("v%0d_raddr", v), 32'(bus.raddr), 32'(vecs[v].raddr));
            step();
            check($sformatf("v%0d_rptr", v), 32'(bus.rptr), 32'(vecs[v].rptr));
            check($sformatf("v%0d_dv", v), 32'(bus.dout_valid), 32'(vecs[v].dv));
            check($sformatf("v%0d_dout", v), 32'(bus.dout), 32'(vecs[v].dout));
            check($sformatf("v%0d_empty", v), 32'(bus.empty), 32'(vecs[v].empty));
            check($sformatf("v%0d_occu", v), 32'(bus.fifo_occu_out), 32'(vecs[v].occu));
            check($sformatf("v%0d_uf", v), 32'(bus.underflow), 32'(vecs[v].uf));
        end

        // Full FIFO: occupancy 16, then drain.
        reset = 1'b1;
        bus.read_enable = 1'b0;
        step();
        reset = 1'b0;
        bus.wptr = 5'd16;
        step();
        check("full_occu", 32'(bus.fifo_occu_out), 32'd16);
        check("full_empty", 32'(bus.empty), 32'd0);
        bus.read_enable = 1'b1;
        for (int k = 0; k < 16; k++) begin
            #1;
            check($sformatf("drain%0d_ren", k), 32'(bus.ren), 32'd1);
            check($sformatf("drain%0d_raddr", k), 32'(bus.raddr), 32'(k));
            step();
            check($sformatf("drain%0d_occu", k), 32'(bus.fifo_occu_out), 32'(16 - k));
            check($sformatf("drain%0d_dout", k), 32'(bus.dout), 32'(mem[k]));
        end
        bus.read_enable = 1'b0;
        step();
        check("drained_occu", 32'(bus.fifo_occu_out), 32'd0);
        check("drained_empty", 32'(bus.empty), 32'd1);
        check("drained_rptr", 32'(bus.rptr), 32'd16);
        check("drained_dout_hold", 32'(bus.dout), 32'hB0);

        // Walk rptr up to 31, then wrap with wptr=1.
        bus.wptr = 5'd31;
        bus.read_enable = 1'b1;
        for (int k = 0; k < 15; k++) step();
        bus.read_enable = 1'b0;
        step();
        check("pre_wrap_rptr", 32'(bus.rptr), 32'd31);
        bus.wptr = 5'd1;
        bus.read_enable = 1'b1;
        #1;
        check("wrap0_ren", 32'(bus.ren), 32'd1);
        check("wrap0_raddr", 32'(bus.raddr), 32'd15);
        step();
        check("wrap0_rptr", 32'(bus.rptr), 32'd0);
        check("wrap0_occu", 32'(bus.fifo_occu_out), 32'd2);
        check("wrap0_dout", 32'(bus.dout), 32'hB0);
        check("wrap1_raddr", 32'(bus.raddr), 32'd0);
        check("wrap1_ren", 32'(bus.ren), 32'd1);
        step();
        check("wrap1_rptr", 32'(bus.rptr), 32'd1);
        check("wrap1_dout", 32'(bus.dout), 32'hA1);
        bus.read_enable = 1'b0;
        step();
        check("wrap_empty", 32'(bus.empty), 32'd1);
        check("wrap_occu", 32'(bus.fifo_occu_out), 32'd0);

        // Pop, then reset in the following cycle: pending data is dropped.
        bus.wptr = 5'd3;
        bus.read_enable = 1'b1;
        step();
        check("prerst_rptr", 32'(bus.rptr), 32'd2);
        reset = 1'b1;
        #1;
        check("rst_gates_ren", 32'(bus.ren), 32'd0);
        step();
        check("midrst_dv", 32'(bus.dout_valid), 32'd0);
        check("midrst_rptr", 32'(bus.rptr), 32'd0);
        check("midrst_empty", 32'(bus.empty), 32'd1);
        check("midrst_dout", 32'(bus.dout), 32'd0);
        check("midrst_uf", 32'(bus.underflow), 32'd0);
        reset = 1'b0;
        bus.read_enable = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_read.md
# fifo_read

Read-side controller of the asynchronous FIFO used by the switch ports; the counterpart to the write-side controller in the same FIFO. Runs entirely in the read clock domain and owns the read pointer. Generates the RAM read address/enable, the empty flag, the read-domain occupancy, and a valid-qualified data output. Consumes the write pointer already synchronized into the read domain and exports its own read pointer for synchronization back to the write side.

## Interface
- `BIT_SIZE`, 10: address width; FIFO depth is 2^BIT_SIZE entries; pointers are BIT_SIZE+1 bits with the MSB as the wrap bit.
- `DATA_WIDTH`, 8: width of one FIFO entry.

- `rclk`  in  1  read-domain clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `read_enable`  in  1  consumer requests one pop this cycle.
- `wptr`  in  BIT_SIZE+1  binary write pointer, already synchronized to `rclk`.
- `mem_rdata`  in  DATA_WIDTH  RAM read data, valid one cycle after `ren`.
- `raddr`  out  BIT_SIZE  RAM read address, equal to `rptr[BIT_SIZE-1:0]`.
- `ren`  out  1  RAM read enable, high in each accepted-pop cycle.
- `rptr`  out  BIT_SIZE+1  binary read pointer, exported to the write side.
- `empty`  out  1  registered empty flag.
- `fifo_occu_out`  out  BIT_SIZE+1  registered occupancy as seen from the read domain.
- `dout`  out  DATA_WIDTH  output data, held stable between pops.
- `dout_valid`  out  1  one-cycle pulse marking new data on `dout`.
- `underflow`  out  1  one-cycle pulse when a pop is requested while empty.

## Operation
- Internal `empty_fifo = (rptr == wptr)` over all BIT_SIZE+1 bits.
- Accepted pop = `read_enable && !empty_fifo && !reset`. `ren` is combinational and equals the accepted pop. `raddr` is combinational from the current `rptr`.
- On an accepted pop, `rptr <= rptr + 1`, modulo 2^(BIT_SIZE+1). The wrap from all-ones to 0 toggles the MSB and requires no special case.
- `dout_valid` is registered and set to the accepted pop of the previous cycle.
- When `dout_valid` is 1, `dout` = `mem_rdata`, and `mem_rdata` is captured into a hold register. Otherwise `dout` = the hold register.
- `empty <= empty_fifo` every cycle.
- `fifo_occu_out <= wptr - rptr` every cycle, with unsigned BIT_SIZE+1-bit modulo arithmetic. Range is 0..2^BIT_SIZE.
- `underflow <= read_enable && empty_fifo`. This is a pulse only: the pointer does not move and `ren` stays 0.
- Full is not checked here. The write side guarantees `wptr - rptr <= 2^BIT_SIZE`.
- Reset values: `rptr` = 0, `empty` = 1, `fifo_occu_out` = 0, `dout_valid` = 0, `dout` = 0 (hold register cleared), `underflow` = 0, `ren` = 0.
- Reset mid-operation: an in-flight `dout_valid` is dropped, meaning reset wins over the pending pulse.

## Timing
- Cycle N, accepted pop:
  - `ren` = 1 and `raddr` = old `rptr`.
  - `rptr` advances at the end of cycle N.
- Cycle N+1:
  - `mem_rdata` is valid and `dout_valid` = 1.
  - `dout` shows that entry combinationally from `mem_rdata`.
- Pop-to-data latency is 1 cycle.
- Back-to-back pops give one entry per cycle with continuous `dout_valid`.
- `empty` and `fifo_occu_out` lag the pointers by 1 cycle. Consumers gate requests on `empty` and tolerate one extra underflow-rejected request after the last pop.
- Simultaneous `wptr` change and pop in one cycle: `empty_fifo` uses the current `wptr` sample, and occupancy reflects both changes one cycle later.

## Structure
- Shared package `fifo_pkg` holds:
  - the default `BIT_SIZE` and `DATA_WIDTH` constants;
  - the typedef for the BIT_SIZE+1-bit pointer/occupancy type;
  - the typedef for the entry type.
  
  The same package is shared with the write side.
- No sub-module: pointer, flags, and the output hold register sit in one flat block.

## Test plan
- Reset with `BIT_SIZE`=4 and `wptr`=0 → `rptr`=0, `empty`=1, `fifo_occu_out`=0, `dout_valid`=0, `underflow`=0.
- `wptr`=3 with `read_enable` held high and RAM entries 0xA1, 0xA2, 0xA3 → `ren` high for 3 cycles at `raddr` 0, 1, 2:
  - `dout_valid` is high for 3 cycles, one cycle later, with `dout` = A1, A2, A3;
  - `rptr` ends at 3;
  - `empty`=1 one cycle after the last pop;
  - one `underflow` pulse on the following cycle.
- Pop request while `rptr`=`wptr`=5 → `ren`=0, `rptr` stays 5, `underflow` pulses once, `dout` holds its previous value.
- Wrap: `rptr`=31, `wptr`=1 (occupancy 2) with two pops → `raddr` 15 then 0, `rptr` goes to 0 then 1, `empty`=1, `fifo_occu_out`=0.
- Full FIFO with `wptr`=16 and `rptr`=0 → `fifo_occu_out`=16 and `empty`=0; draining 16 pops gives `fifo_occu_out` counting down to 0.
- Reset asserted in the cycle after a pop → `dout_valid` stays 0, `rptr`=0, `empty`=1 on the next cycle.
